// File: rtl/product_accumulator_pkg.sv
// rtl/product_accumulator_pkg.sv - shared types and saturating add for the product accumulator
package acc_pkg;

  localparam int PRODUCT_W = 6;
  localparam int SAT_MAX_W = 32;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Adds two operands (zero-extended to SAT_MAX_W) and clamps to 2^acc_w-1.
  // Returns {ovf, sum}; sum never exceeds the acc_w-bit maximum.
  function automatic logic [SAT_MAX_W:0] sat_add(
    input int                   acc_w,
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b
  );
    logic [SAT_MAX_W:0] one;
    logic [SAT_MAX_W:0] full;
    logic [SAT_MAX_W:0] lim;
    one  = {{SAT_MAX_W{1'b0}}, 1'b1};
    full = {1'b0, a} + {1'b0, b};
    lim  = (one << acc_w) - one;
    if (full > lim) begin
      sat_add = {1'b1, lim[SAT_MAX_W-1:0]};
    end else begin
      sat_add = {1'b0, full[SAT_MAX_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - product input stream and frame result port
interface product_accumulator_if #(
  parameter int ACC_W = 10,
  parameter int CNT_W = 3
);

  logic                          in_valid;
  logic                          in_ready;
  logic [acc_pkg::PRODUCT_W-1:0] in_product;
  logic                          in_last;
  logic                          out_valid;
  logic                          out_ready;
  logic [ACC_W-1:0]              out_sum;
  logic [CNT_W-1:0]              out_count;
  logic                          out_ovf;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - saturating frame accumulator of multiplier products
module product_accumulator
  import acc_pkg::*;
#(
  parameter int FRAME_LEN = 4,
  parameter int ACC_W     = 10,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  product_accumulator_if.slave bus
);

  state_e               r_state;
  logic [ACC_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf;
  logic [ACC_W-1:0]     r_out_sum;
  logic [CNT_W-1:0]     r_out_count;
  logic                 r_out_ovf;

  logic                 w_accept;
  logic                 w_frame_end;
  logic [SAT_MAX_W:0]   w_add;
  logic [ACC_W-1:0]     w_acc_next;
  logic                 w_ovf_next;
  logic [CNT_W-1:0]     w_cnt_next;

  // Handshake flags are pure state decodes, so no input reaches an output combinationally.
  assign bus.in_ready  = (r_state == ACCUM);
  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_sum   = r_out_sum;
  assign bus.out_count = r_out_count;
  assign bus.out_ovf   = r_out_ovf;

  assign w_accept    = (r_state == ACCUM) && bus.in_valid;
  assign w_frame_end = w_accept && ((r_cnt == CNT_W'(FRAME_LEN - 1)) || bus.in_last);

  // The upper bits of the clamped sum are always zero; folding them into the
  // overflow flag keeps every bit of the adder result meaningful.
  assign w_add      = sat_add(ACC_W, SAT_MAX_W'(r_acc), SAT_MAX_W'(bus.in_product));
  assign w_acc_next = w_add[ACC_W-1:0];
  assign w_ovf_next = r_ovf | w_add[SAT_MAX_W] | (|w_add[SAT_MAX_W-1:ACC_W]);
  assign w_cnt_next = r_cnt + CNT_W'(1);

  // Frame state machine: accumulate beats, publish at frame end, hold until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (r_state == ACCUM) begin
      if (w_accept) begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
        r_ovf <= w_ovf_next;
        if (w_frame_end) begin
          r_out_sum   <= w_acc_next;
          r_out_count <= w_cnt_next;
          r_out_ovf   <= w_ovf_next;
          r_state     <= HOLD;
        end
      end
    end else begin
      if (bus.out_ready) begin
        r_acc   <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
        r_state <= ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - self-checking bench for product_accumulator
module tb_product_accumulator;

  localparam int FL = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [5:0] in_product;
  logic       in_last;
  logic       out_ready;

  product_accumulator_if #(.ACC_W(10), .CNT_W(3)) b10 ();
  product_accumulator_if #(.ACC_W(6),  .CNT_W(3)) b6 ();

  assign b10.in_valid   = in_valid;
  assign b10.in_product = in_product;
  assign b10.in_last    = in_last;
  assign b10.out_ready  = out_ready;
  assign b6.in_valid    = in_valid;
  assign b6.in_product  = in_product;
  assign b6.in_last     = in_last;
  assign b6.out_ready   = out_ready;

  product_accumulator #(.FRAME_LEN(FL), .ACC_W(10)) dut10 (.clk(clk), .rst(rst), .bus(b10));
  product_accumulator #(.FRAME_LEN(FL), .ACC_W(6))  dut6  (.clk(clk), .rst(rst), .bus(b6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: the list of products accepted in the open frame, plus the
  // published result. Sums are computed as plain integers and clamped at the end.
  int q[$];
  bit m_hold;
  bit m_known;
  int m_sum10, m_sum6, m_cnt;
  bit m_ovf10, m_ovf6;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_close();
    int total;
    total = 0;
    foreach (q[i]) total += q[i];
    m_sum10 = (total > 1023) ? 1023 : total;
    m_ovf10 = (total > 1023);
    m_sum6  = (total > 63) ? 63 : total;
    m_ovf6  = (total > 63);
    m_cnt   = q.size();
    q.delete();
  endfunction

  task automatic step(input bit v, input int p, input bit l, input bit ordy, input bit r);
    in_valid   = v;
    in_product = p[5:0];
    in_last    = l;
    out_ready  = ordy;
    rst        = r;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_hold = 0; m_known = 1;
      m_sum10 = 0; m_sum6 = 0; m_cnt = 0; m_ovf10 = 0; m_ovf6 = 0;
    end else if (!m_hold) begin
      if (v) begin
        q.push_back(p & 63);
        if (q.size() == FL || l) begin
          model_close();
          m_hold = 1; m_known = 1;
        end
      end
    end else if (ordy) begin
      m_hold = 0; m_known = 0;
    end
    #1;
    chk("in_ready10",  32'(b10.in_ready),  32'(!m_hold));
    chk("out_valid10", 32'(b10.out_valid), 32'(m_hold));
    chk("in_ready6",   32'(b6.in_ready),   32'(!m_hold));
    chk("out_valid6",  32'(b6.out_valid),  32'(m_hold));
    if (m_known) begin
      chk("out_sum10",   32'(b10.out_sum),   32'(m_sum10));
      chk("out_ovf10",   32'(b10.out_ovf),   32'(m_ovf10));
      chk("out_count10", 32'(b10.out_count), 32'(m_cnt));
      chk("out_sum6",    32'(b6.out_sum),    32'(m_sum6));
      chk("out_ovf6",    32'(b6.out_ovf),    32'(m_ovf6));
      chk("out_count6",  32'(b6.out_count),  32'(m_cnt));
    end
  endtask

  typedef struct {
    int n;
    int p[4];
    bit last;
    int s10;
    int s6;
    int cnt;
    bit o10;
    bit o6;
  } frame_t;

  frame_t tbl[8];
  int     bub[7];

  initial begin
    tbl[0] = '{4, '{7, 14, 21, 49}, 1'b0, 91, 63, 4, 1'b0, 1'b1};
    tbl[1] = '{4, '{49, 49, 0, 0},  1'b0, 98, 63, 4, 1'b0, 1'b1};
    tbl[2] = '{4, '{1, 1, 1, 1},    1'b0, 4,  4,  4, 1'b0, 1'b0};
    tbl[3] = '{2, '{10, 5, 0, 0},   1'b1, 15, 15, 2, 1'b0, 1'b0};
    tbl[4] = '{4, '{1, 1, 1, 1},    1'b0, 4,  4,  4, 1'b0, 1'b0};
    tbl[5] = '{4, '{63, 63, 63, 63},1'b0, 252,63, 4, 1'b0, 1'b1};
    tbl[6] = '{1, '{0, 0, 0, 0},    1'b1, 0,  0,  1, 1'b0, 1'b0};
    tbl[7] = '{1, '{33, 0, 0, 0},   1'b1, 33, 33, 1, 1'b0, 1'b0};
    bub    = '{1, 0, 0, 1, 1, 0, 1};

    q.delete();
    m_hold = 0; m_known = 0;

    // Reset state.
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);

    // Table of frames, continuous valid, out_ready high.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < tbl[k].n; i++) begin
        step(1, tbl[k].p[i], tbl[k].last && (i == tbl[k].n - 1), 1, 0);
      end
      chk("tbl_valid",   32'(b10.out_valid), 32'd1);
      chk("tbl_ready",   32'(b10.in_ready),  32'd0);
      chk("tbl_sum10",   32'(b10.out_sum),   32'(tbl[k].s10));
      chk("tbl_ovf10",   32'(b10.out_ovf),   32'(tbl[k].o10));
      chk("tbl_cnt10",   32'(b10.out_count), 32'(tbl[k].cnt));
      chk("tbl_sum6",    32'(b6.out_sum),    32'(tbl[k].s6));
      chk("tbl_ovf6",    32'(b6.out_ovf),    32'(tbl[k].o6));
      step(0, 0, 0, 1, 0);
      chk("tbl_ready_after", 32'(b10.in_ready), 32'd1);
    end

    // Backpressure: result held for 5 cycles while a product is pending upstream.
    step(1, 2, 0, 0, 0); step(1, 3, 0, 0, 0); step(1, 4, 0, 0, 0); step(1, 5, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 9, 0, 0, 0);
    chk("bp_sum_held", 32'(b10.out_sum), 32'd14);
    step(1, 9, 0, 1, 0);
    step(1, 9, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
    chk("bp_next_sum", 32'(b10.out_sum),   32'd12);
    chk("bp_next_cnt", 32'(b10.out_count), 32'd4);
    step(0, 0, 0, 1, 0);

    // Bubbles on in_valid.
    for (int i = 0; i < 7; i++) step(bub[i] != 0, 3, 0, 1, 0);
    chk("bub_sum", 32'(b10.out_sum),   32'd12);
    chk("bub_cnt", 32'(b10.out_count), 32'd4);
    step(0, 0, 0, 1, 0);

    // Reset mid-frame, then a fresh frame; reset also overrides a concurrent beat.
    step(1, 20, 0, 1, 0); step(1, 30, 0, 1, 0);
    step(1, 5, 0, 1, 1);
    chk("rst_sum", 32'(b10.out_sum), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 2, 0, 1, 0);
    chk("rst_frame_sum", 32'(b10.out_sum),   32'd8);
    chk("rst_frame_cnt", 32'(b10.out_count), 32'd4);
    step(0, 0, 0, 0, 1);
    chk("rst_hold_valid", 32'(b10.out_valid), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 63)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulation stage that sits directly downstream of the 3-bit combinational multiplier. It accepts a stream of 6-bit unsigned products over a valid/ready handshake and sums a frame of up to FRAME_LEN products. It presents the frame sum, beat count and a saturation flag on a valid/ready output port. Together with the multiplier it forms a small dot-product / MAC datapath.

## Interface
- FRAME_LEN, 4: products per frame. Legal range is ≥1.
- ACC_W, 10: accumulator width. Legal range is ≥6.
- CNT_W, $clog2(FRAME_LEN+1): derived; not to be overridden.

- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream product valid
- in_ready  out  1  block can accept a product
- in_product  in  6  unsigned product, 0..49 in normal use; full 0..63 must be handled
- in_last  in  1  qualifies the current beat as the final beat of the frame (early termination)
- out_valid  out  1  frame result valid
- out_ready  in  1  downstream accepts the result
- out_sum  out  ACC_W  saturated frame sum
- out_count  out  CNT_W  number of products accepted in the frame (1..FRAME_LEN)
- out_ovf  out  1  set if any addition in the frame saturated

## Operation
- There are two states: ACCUM and HOLD. Reset state is ACCUM.
- **ACCUM**
  - in_ready=1 and out_valid=0.
  - A beat is accepted when in_valid&&in_ready.
  - On an accepted beat: acc ← sat(acc + zero-extended in_product) and cnt ← cnt+1.
  - ovf_sticky is set if the unclamped sum exceeds 2^ACC_W−1.
- **Frame end**: an accepted beat with cnt==FRAME_LEN−1, or with in_last=1. At frame end:
  - out_sum, out_count and out_ovf are loaded from the post-add values.
  - The state goes to HOLD.
- **HOLD**
  - in_ready=0 and out_valid=1.
  - Outputs stay stable until out_valid&&out_ready.
  - On that handshake: acc, cnt and ovf_sticky are cleared, and the state returns to ACCUM.
- **Saturation**: clamp to 2^ACC_W−1. The accumulator never wraps.
- in_last is sampled only on accepted beats. When cnt reaches FRAME_LEN−1, the frame ends regardless of in_last.
- in_valid while in HOLD is ignored; the beat stays pending upstream.
- There are no empty frames: every frame has at least one beat, so out_count≥1.
- rst at any time, including mid-frame or in HOLD:
  - The partial frame is discarded.
  - All outputs and state return to reset values on the next edge.
  - rst overrides any concurrent handshake.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0. State is ACCUM; acc, cnt and ovf_sticky are 0.
- All outputs are registered or decoded from state only. There is no combinational path from input to output.
- Latency: out_valid rises on the edge that accepts the frame's last beat, so the result is visible the cycle after that beat.
- Throughput: one product per cycle within a frame. Minimum one HOLD cycle between frames, so the earliest next-frame beat is accepted in the cycle after the out handshake.
- in_ready deasserts in the same cycle out_valid asserts.

## Structure
- Package acc_pkg holds:
  - PRODUCT_W=6
  - state enum {ACCUM, HOLD}
  - a sat_add function (width-parameterised via ACC_W argument, returns {ovf, sum})
- No sub-module is required.
- Optional: the saturating adder can be factored into sat_adder (ACC_W parameter), combinational, reused by later MAC stages.

## Test plan
- Defaults, frame of 7, 14, 21, 49 with in_valid continuous, out_ready=1:
  - out_valid one cycle after the 4th beat, with out_sum=91, out_count=4, out_ovf=0.
  - in_ready low exactly during that HOLD cycle.
- ACC_W=6, FRAME_LEN=4, beats 49, 49, 0, 0:
  - out_sum=63, out_ovf=1, out_count=4.
  - Next frame 1, 1, 1, 1 gives out_sum=4, out_ovf=0 (sticky cleared).
- Early termination, beats 10 then 5 with in_last=1:
  - out_sum=15, out_count=2.
  - A following full frame of 4×1 gives out_sum=4, out_count=4.
- Backpressure, out_ready=0 for 5 cycles after a result:
  - out_sum, out_count and out_ovf stay stable, in_ready=0, and upstream in_valid=1 beats are not consumed.
  - On release, the first pending product lands in the new frame.
- Bubbles, in_valid toggling 1, 0, 0, 1, 1, 0, 1 with products of 3:
  - Only accepted beats count, giving out_sum=12 and out_count=4.
- Reset mid-frame after 2 beats (20, 30), rst high 1 cycle, then 4×2:
  - Outputs at reset values during rst.
  - Result out_sum=8, out_count=4.
  - Reset asserted in HOLD clears out_valid on the next edge.
